// File: rtl/dds_sample_source.sv
// Sine sample source: phase accumulator ticked every CLK_DIV enabled cycles,
// quarter-wave table with quadrant mirroring and sign restore, 3-cycle pipeline.
module dds_sample_source #(
  parameter int                     DATA_WIDTH     = 24,
  parameter int                     PHASE_WIDTH    = 32,
  parameter int                     LUT_ADDR_WIDTH = 8,
  parameter int                     CLK_DIV        = 2273,
  parameter logic [PHASE_WIDTH-1:0] TW_RESET       = PHASE_WIDTH'(97612893),
  parameter string                  LUT_INIT_FILE  = "quarter_sine.mem"
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_en,
  input  logic [PHASE_WIDTH-1:0]        iv_tuning_word,
  input  logic                          i_tw_load,
  output logic signed [DATA_WIDTH-1:0]  ov_dout,
  output logic                          o_valid
);

  localparam int  LUT_DEPTH = 1 << LUT_ADDR_WIDTH;
  localparam int  CNT_W     = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
  localparam real PI        = 3.14159265358979323846;
  localparam real AMPL      = real'((longint'(1) << (DATA_WIDTH - 1)) - 1);

  if (CLK_DIV < 4 || LUT_INIT_FILE == "") begin : g_param_check
    $error("dds_sample_source: CLK_DIV must be >= 4 and LUT_INIT_FILE must name the table image");
  end

  function automatic logic signed [DATA_WIDTH-1:0] apply_sign(
    input logic                         neg,
    input logic signed [DATA_WIDTH-1:0] mag
  );
    // Entries never exceed 2^(DATA_WIDTH-1)-1, so the negation cannot overflow.
    return neg ? -mag : mag;
  endfunction

  // Table contents are the closed-form entries that LUT_INIT_FILE also holds,
  // built at elaboration so no file access is needed.
  logic signed [DATA_WIDTH-1:0] lut [LUT_DEPTH];

  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
    localparam real ANGLE = (2.0 * k + 1.0) * PI / real'(4 * LUT_DEPTH);
    localparam int  ENTRY = $rtoi(AMPL * $sin(ANGLE) + 0.5);
    assign lut[k] = DATA_WIDTH'(ENTRY);
  end

  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [PHASE_WIDTH-1:0]         tw_q, tw_d;
  logic [PHASE_WIDTH-1:0]         phase_q, phase_d;
  logic                           tick;
  logic [1:0]                     quad;
  logic [LUT_ADDR_WIDTH-1:0]      idx;
  logic [LUT_ADDR_WIDTH-1:0]      addr_p0_q, addr_p0_d;
  logic                           neg_p0_q, neg_p0_d;
  logic                           vld_p0_q, vld_p0_d;
  logic signed [DATA_WIDTH-1:0]   entry_p1_q, entry_p1_d;
  logic                           neg_p1_q, neg_p1_d;
  logic                           vld_p1_q, vld_p1_d;
  logic signed [DATA_WIDTH-1:0]   dout_p2_q, dout_p2_d;
  logic                           vld_p2_q, vld_p2_d;

  always_comb begin
    tick    = i_en && (cnt_q == CNT_MAX);
    cnt_d   = cnt_q;
    if (i_en) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
    // A load coinciding with a tick is seen only by later ticks.
    tw_d    = i_tw_load ? iv_tuning_word : tw_q;
    phase_d = tick ? phase_q + tw_q : phase_q;

    // Stage p0: quadrant fold of the pre-increment phase
    quad      = phase_q[PHASE_WIDTH-1 -: 2];
    idx       = phase_q[PHASE_WIDTH-3 -: LUT_ADDR_WIDTH];
    addr_p0_d = tick ? (quad[0] ? ~idx : idx) : addr_p0_q;
    neg_p0_d  = tick ? quad[1] : neg_p0_q;
    vld_p0_d  = tick;

    // Stage p1: registered table read
    entry_p1_d = vld_p0_q ? lut[addr_p0_q] : entry_p1_q;
    neg_p1_d   = vld_p0_q ? neg_p0_q : neg_p1_q;
    vld_p1_d   = vld_p0_q;

    // Stage p2: sign restore; output holds between strobes
    dout_p2_d = vld_p1_q ? apply_sign(neg_p1_q, entry_p1_q) : dout_p2_q;
    vld_p2_d  = vld_p1_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q      <= '0;
      tw_q       <= TW_RESET;
      phase_q    <= '0;
      addr_p0_q  <= '0;
      neg_p0_q   <= 1'b0;
      vld_p0_q   <= 1'b0;
      entry_p1_q <= '0;
      neg_p1_q   <= 1'b0;
      vld_p1_q   <= 1'b0;
      dout_p2_q  <= '0;
      vld_p2_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      tw_q       <= tw_d;
      phase_q    <= phase_d;
      addr_p0_q  <= addr_p0_d;
      neg_p0_q   <= neg_p0_d;
      vld_p0_q   <= vld_p0_d;
      entry_p1_q <= entry_p1_d;
      neg_p1_q   <= neg_p1_d;
      vld_p1_q   <= vld_p1_d;
      dout_p2_q  <= dout_p2_d;
      vld_p2_q   <= vld_p2_d;
    end
  end

  assign ov_dout = dout_p2_q;
  assign o_valid = vld_p2_q;

endmodule
